// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-RAM initiator: memory op codes, FSM states,
// RAM bus encodings and the alignment rule used by both the FSM and the lane aligner.
package mem_access_unit_pkg;

    typedef logic [2:0]  mem_op_bus_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  byte_sel_t;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        MEM_OP_LB  = 3'd0,
        MEM_OP_LBU = 3'd1,
        MEM_OP_LH  = 3'd2,
        MEM_OP_LHU = 3'd3,
        MEM_OP_LW  = 3'd4,
        MEM_OP_SB  = 3'd5,
        MEM_OP_SH  = 3'd6,
        MEM_OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] offset);
        logic result;
        result = 1'b0;
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: result = offset[0];
            MEM_OP_LW, MEM_OP_SW:             result = (offset != 2'b00);
            default:                          result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// MEM-stage request/response handshake plus the single-port data-RAM bus.
// slave is the unit's view; master is the MEM stage and RAM together.
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic        req_valid;
    logic        req_ready;
    mem_op_bus_t req_op;
    word_t       req_addr;
    word_t       req_wdata;
    logic        resp_valid;
    word_t       resp_rdata;
    logic        resp_error;
    logic        stall_request;
    logic        ram_chip_enable;
    logic        ram_operation;
    word_t       ram_addr;
    byte_sel_t   ram_select;
    word_t       ram_write_data;
    word_t       ram_read_data;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, ram_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error, stall_request,
               ram_chip_enable, ram_operation, ram_addr, ram_select, ram_write_data
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, ram_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall_request,
               ram_chip_enable, ram_operation, ram_addr, ram_select, ram_write_data
    );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: select pattern, replicated store lanes,
// extended load value and misalignment flag for one access.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_op_e    op,
    input  logic [1:0] offset,
    input  word_t      wdata,
    input  word_t      rdata,
    output byte_sel_t  select,
    output word_t      write_lanes,
    output word_t      load_data,
    output logic       misaligned
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Offset 0 is the most significant lane.
    always_comb begin
        byte_val = 8'h00;
        case (offset)
            2'd0: byte_val = rdata[31:24];
            2'd1: byte_val = rdata[23:16];
            2'd2: byte_val = rdata[15:8];
            2'd3: byte_val = rdata[7:0];
            default: byte_val = 8'h00;
        endcase
        half_val = offset[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        select      = 4'b0000;
        write_lanes = '0;
        load_data   = '0;
        case (op)
            MEM_OP_LB: begin
                select    = 4'b1000 >> offset;
                load_data = {{24{byte_val[7]}}, byte_val};
            end
            MEM_OP_LBU: begin
                select    = 4'b1000 >> offset;
                load_data = {24'h000000, byte_val};
            end
            MEM_OP_LH: begin
                select    = offset[1] ? 4'b0011 : 4'b1100;
                load_data = {{16{half_val[15]}}, half_val};
            end
            MEM_OP_LHU: begin
                select    = offset[1] ? 4'b0011 : 4'b1100;
                load_data = {16'h0000, half_val};
            end
            MEM_OP_LW: begin
                select    = 4'b1111;
                load_data = rdata;
            end
            MEM_OP_SB: begin
                select      = 4'b1000 >> offset;
                write_lanes = {4{wdata[7:0]}};
            end
            MEM_OP_SH: begin
                select      = offset[1] ? 4'b0011 : 4'b1100;
                write_lanes = {2{wdata[15:0]}};
            end
            MEM_OP_SW: begin
                select      = 4'b1111;
                write_lanes = wdata;
            end
            default: ;
        endcase
        misaligned = is_misaligned(op, offset);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-RAM initiator: one load/store at a time, IDLE -> ACCESS (WAIT_CYCLES+1 cycles)
// -> RESP, with misaligned requests answered from IDLE without touching the RAM.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    state_e     state;
    state_e     next_state;
    mem_op_e    op_q;
    word_t      addr_q;
    word_t      wdata_q;
    word_t      rdata_q;
    logic [3:0] wait_cnt;
    logic       last_wait;
    byte_sel_t  lane_select;
    word_t      lane_write;
    word_t      lane_load;
    logic       lane_misaligned;

    assign last_wait = (wait_cnt == 4'(WAIT_CYCLES));

    mem_lane_align u_lane_align (
        .op          (op_q),
        .offset      (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (bus.ram_read_data),
        .select      (lane_select),
        .write_lanes (lane_write),
        .load_data   (lane_load),
        .misaligned  (lane_misaligned)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Misaligned requests skip ACCESS so the RAM never sees them.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    next_state = is_misaligned(mem_op_e'(bus.req_op), bus.req_addr[1:0]) ? RESP : ACCESS;
                end
            end
            ACCESS:  next_state = last_wait ? RESP : ACCESS;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q     <= MEM_OP_LB;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q     <= mem_op_e'(bus.req_op);
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        rdata_q  <= '0;
                        wait_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (last_wait) begin
                        wait_cnt <= '0;
                        if (!is_store(op_q)) begin
                            rdata_q <= lane_load;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM outputs depend only on registered state, never on the incoming request.
    always_comb begin
        bus.req_ready       = (state == IDLE);
        bus.stall_request   = ((state == IDLE) && bus.req_valid) || (state == ACCESS);
        bus.resp_valid      = (state == RESP);
        bus.resp_error      = (state == RESP) && lane_misaligned;
        bus.resp_rdata      = rdata_q;
        bus.ram_chip_enable = DISABLE;
        bus.ram_operation   = RAM_READ;
        bus.ram_addr        = '0;
        bus.ram_select      = 4'b0000;
        bus.ram_write_data  = '0;
        if (state == ACCESS) begin
            bus.ram_chip_enable = ENABLE;
            bus.ram_operation   = is_store(op_q) ? RAM_WRITE : RAM_READ;
            bus.ram_addr        = {addr_q[31:2], 2'b00};
            bus.ram_select      = lane_select;
            bus.ram_write_data  = lane_write;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table and randomized ops on a WAIT_CYCLES=0 unit
// against a byte-array memory model, plus latency and reset sequences.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mem_access_unit_if bus0 ();
    mem_access_unit_if bus3 ();

    mem_access_unit #(.WAIT_CYCLES(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    mem_access_unit #(.WAIT_CYCLES(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

    logic [31:0] ram_words [0:63];
    logic [7:0]  ref_mem   [0:255];

    assign bus0.ram_read_data = ram_words[bus0.ram_addr[7:2]];
    assign bus3.ram_read_data = 32'h8BAD_F00D;

    // Single-port RAM behind dut0: byte-lane write on the clock edge.
    always @(posedge clock) begin
        if (bus0.ram_chip_enable && bus0.ram_operation == RAM_WRITE) begin
            for (int l = 0; l < 4; l++) begin
                if (bus0.ram_select[l]) ram_words[bus0.ram_addr[7:2]][8*l +: 8] = bus0.ram_write_data[8*l +: 8];
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sel;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [0:24];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
    endfunction

    // Model: an access touches `size` consecutive bytes, most significant byte at the lowest address.
    task automatic ref_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err,
                              output logic [3:0] sel, output logic [31:0] wd);
        int size;
        int a;
        logic [31:0] v;
        size  = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 : (op == 3'd4 || op == 3'd7) ? 4 : 2;
        a     = int'(addr);
        err   = (a % size) != 0;
        rdata = '0;
        sel   = '0;
        wd    = '0;
        if (!err) begin
            for (int i = 0; i < size; i++) sel[3 - ((a + i) % 4)] = 1'b1;
            if (op >= 3'd5) begin
                for (int i = 0; i < size; i++) ref_mem[a + i] = wdata[8*(size-1-i) +: 8];
                for (int l = 0; l < 4; l++) wd[8*l +: 8] = wdata[8*(l % size) +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = (v << 8) | 32'(ref_mem[a + i]);
                if ((op == 3'd0 || op == 3'd2) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rdata = v;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err, output int lat,
                                  output logic saw_ce, output logic [3:0] sel, output logic [31:0] wd,
                                  output logic ramop, output logic [31:0] raddr, output logic stall_ok);
        bit done;
        @(posedge clock); #1;
        bus0.req_valid = 1'b1;
        bus0.req_op    = op;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        #1;
        stall_ok = bus0.stall_request && bus0.req_ready;
        saw_ce = 1'b0; sel = '0; wd = '0; ramop = 1'b0; raddr = '0;
        rdata = '0; err = 1'b0; lat = -1; done = 1'b0;
        for (int c = 1; c <= 30 && !done; c++) begin
            @(posedge clock); #1;
            if (bus0.ram_chip_enable && !saw_ce) begin
                saw_ce = 1'b1;
                sel    = bus0.ram_select;
                wd     = bus0.ram_write_data;
                ramop  = bus0.ram_operation;
                raddr  = bus0.ram_addr;
            end
            if (bus0.stall_request === bus0.resp_valid) stall_ok = 1'b0;
            if (bus0.resp_valid) begin
                done  = 1'b1;
                lat   = c;
                rdata = bus0.resp_rdata;
                err   = bus0.resp_error;
            end
        end
        bus0.req_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic [3:0] exp_sel, input logic [31:0] exp_wd);
        logic [31:0] rdata, wd, raddr;
        logic        err, saw_ce, ramop, stall_ok;
        logic [3:0]  sel;
        int          lat;
        apply_stimulus(op, addr, wdata, rdata, err, lat, saw_ce, sel, wd, ramop, raddr, stall_ok);
        check_output({tag, "_rdata"}, rdata, exp_rdata);
        check_output({tag, "_error"}, 32'(err), 32'(exp_err));
        check_output({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
        check_output({tag, "_stall"}, 32'(stall_ok), 32'd1);
        if (exp_err) begin
            check_output({tag, "_ce"}, 32'(saw_ce), 32'd0);
        end else begin
            check_output({tag, "_select"}, 32'(sel), 32'(exp_sel));
            check_output({tag, "_wdata"}, wd, exp_wd);
            check_output({tag, "_ramop"}, 32'(ramop), (op >= 3'd5) ? 32'd1 : 32'd0);
            check_output({tag, "_ramaddr"}, raddr, {addr[31:2], 2'b00});
        end
    endtask

    initial begin
        logic [31:0] e_rd, e_wd, val, pre;
        logic        e_err, seen_resp;
        logic [3:0]  e_sel;
        logic [2:0]  op;
        logic [31:0] addr;
        int          bad, lat, stall_cnt;
        logic [2:0]  w3_op   [0:2];
        logic [31:0] w3_addr [0:2];
        logic [31:0] w3_exp  [0:2];

        bus0.req_valid = 0; bus0.req_op = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
        bus3.req_valid = 0; bus3.req_op = 0; bus3.req_addr = 0; bus3.req_wdata = 0;
        for (int w = 0; w < 64; w++) ram_words[w] = '0;
        for (int b = 0; b < 256; b++) ref_mem[b] = '0;

        vecs[0]  = '{MEM_OP_SW,  32'h10, 32'h11223344, 32'h0,        1'b0, 4'b1111, 32'h11223344};
        vecs[1]  = '{MEM_OP_LW,  32'h10, 32'h0,        32'h11223344, 1'b0, 4'b1111, 32'h0};
        vecs[2]  = '{MEM_OP_SB,  32'h13, 32'h12345680, 32'h0,        1'b0, 4'b0001, 32'h80808080};
        vecs[3]  = '{MEM_OP_LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0001, 32'h0};
        vecs[4]  = '{MEM_OP_LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, 4'b0001, 32'h0};
        vecs[5]  = '{MEM_OP_LW,  32'h10, 32'h0,        32'h11223380, 1'b0, 4'b1111, 32'h0};
        vecs[6]  = '{MEM_OP_LBU, 32'h10, 32'h0,        32'h00000011, 1'b0, 4'b1000, 32'h0};
        vecs[7]  = '{MEM_OP_LB,  32'h11, 32'h0,        32'h00000022, 1'b0, 4'b0100, 32'h0};
        vecs[8]  = '{MEM_OP_SW,  32'h20, 32'hA1B2C3D4, 32'h0,        1'b0, 4'b1111, 32'hA1B2C3D4};
        vecs[9]  = '{MEM_OP_SH,  32'h22, 32'h5555BEEF, 32'h0,        1'b0, 4'b0011, 32'hBEEFBEEF};
        vecs[10] = '{MEM_OP_LH,  32'h22, 32'h0,        32'hFFFFBEEF, 1'b0, 4'b0011, 32'h0};
        vecs[11] = '{MEM_OP_LHU, 32'h20, 32'h0,        32'h0000A1B2, 1'b0, 4'b1100, 32'h0};
        vecs[12] = '{MEM_OP_LH,  32'h20, 32'h0,        32'hFFFFA1B2, 1'b0, 4'b1100, 32'h0};
        vecs[13] = '{MEM_OP_LW,  32'h20, 32'h0,        32'hA1B2BEEF, 1'b0, 4'b1111, 32'h0};
        vecs[14] = '{MEM_OP_LW,  32'h06, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
        vecs[15] = '{MEM_OP_LH,  32'h01, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
        vecs[16] = '{MEM_OP_SW,  32'h22, 32'hFFFFFFFF, 32'h0,        1'b1, 4'b0000, 32'h0};
        vecs[17] = '{MEM_OP_SH,  32'h23, 32'h00001234, 32'h0,        1'b1, 4'b0000, 32'h0};
        vecs[18] = '{MEM_OP_SB,  32'h22, 32'h0000007F, 32'h0,        1'b0, 4'b0010, 32'h7F7F7F7F};
        vecs[19] = '{MEM_OP_LB,  32'h22, 32'h0,        32'h0000007F, 1'b0, 4'b0010, 32'h0};
        vecs[20] = '{MEM_OP_LHU, 32'h22, 32'h0,        32'h00007FEF, 1'b0, 4'b0011, 32'h0};
        vecs[21] = '{MEM_OP_LW,  32'h20, 32'h0,        32'hA1B27FEF, 1'b0, 4'b1111, 32'h0};
        vecs[22] = '{MEM_OP_SH,  32'h20, 32'h000080A0, 32'h0,        1'b0, 4'b1100, 32'h80A080A0};
        vecs[23] = '{MEM_OP_LH,  32'h20, 32'h0,        32'hFFFF80A0, 1'b0, 4'b1100, 32'h0};
        vecs[24] = '{MEM_OP_LB,  32'h21, 32'h0,        32'hFFFFFFA0, 1'b0, 4'b0100, 32'h0};

        repeat (3) @(posedge clock);
        #1;
        check_output("reset_req_ready", 32'(bus0.req_ready), 32'd1);
        check_output("reset_resp_valid", 32'(bus0.resp_valid), 32'd0);
        check_output("reset_resp_rdata", bus0.resp_rdata, 32'd0);
        check_output("reset_resp_error", 32'(bus0.resp_error), 32'd0);
        check_output("reset_stall", 32'(bus0.stall_request), 32'd0);
        check_output("reset_ram_ctrl", {26'd0, bus0.ram_chip_enable, bus0.ram_operation, bus0.ram_select}, 32'd0);
        check_output("reset_ram_addr", bus0.ram_addr, 32'd0);
        check_output("reset_ram_wdata", bus0.ram_write_data, 32'd0);
        #2 reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            ref_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, e_rd, e_err, e_sel, e_wd);
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].err, vecs[i].sel, vecs[i].wd);
        end

        for (int w = 0; w < 64; w++) begin
            val = $urandom;
            ram_words[w] = val;
            for (int k = 0; k < 4; k++) ref_mem[4*w + k] = val[8*(3-k) +: 8];
        end
        for (int i = 0; i < 200; i++) begin
            op   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 255));
            val  = $urandom;
            ref_access(op, addr, val, e_rd, e_err, e_sel, e_wd);
            run_one($sformatf("rnd%0d", i), op, addr, val, e_rd, e_err, e_sel, e_wd);
        end

        // Reset mid-ACCESS of SW @0x30: write must not land and no response appears.
        ram_words[12] = 32'h01020304;
        for (int k = 0; k < 4; k++) ref_mem[48 + k] = 8'(k + 1);
        pre = 32'h01020304;
        @(posedge clock); #1;
        bus0.req_valid = 1'b1; bus0.req_op = MEM_OP_SW; bus0.req_addr = 32'h30; bus0.req_wdata = 32'hDEADBEEF;
        @(posedge clock); #1;
        check_output("rst_ce_before", 32'(bus0.ram_chip_enable), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("rst_ce_dropped", 32'(bus0.ram_chip_enable), 32'd0);
        bus0.req_valid = 1'b0;
        @(posedge clock); #1;
        check_output("rst_mem_unchanged", ram_words[12], pre);
        #2 reset = 1'b1;
        seen_resp = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            if (bus0.resp_valid) seen_resp = 1'b1;
        end
        check_output("rst_no_resp", 32'(seen_resp), 32'd0);
        check_output("rst_req_ready", 32'(bus0.req_ready), 32'd1);

        bad = 0;
        for (int w = 0; w < 64; w++) if (ram_words[w] !== ref_word(4*w)) bad++;
        check_output("mem_final_bad_words", 32'(bad), 32'd0);

        // WAIT_CYCLES=3: load latency and stall window, read word fixed at 0x8BADF00D.
        w3_op[0] = MEM_OP_LW;  w3_addr[0] = 32'h44; w3_exp[0] = 32'h8BADF00D;
        w3_op[1] = MEM_OP_LB;  w3_addr[1] = 32'h45; w3_exp[1] = 32'hFFFFFFAD;
        w3_op[2] = MEM_OP_LHU; w3_addr[2] = 32'h46; w3_exp[2] = 32'h0000F00D;
        for (int t = 0; t < 3; t++) begin
            @(posedge clock); #1;
            bus3.req_valid = 1'b1; bus3.req_op = w3_op[t]; bus3.req_addr = w3_addr[t]; bus3.req_wdata = '0;
            #1;
            stall_cnt = bus3.stall_request ? 1 : 0;
            lat = -1;
            val = '0;
            for (int c = 1; c <= 30 && lat < 0; c++) begin
                @(posedge clock); #1;
                if (bus3.stall_request) stall_cnt++;
                if (bus3.resp_valid) begin
                    lat = c;
                    val = bus3.resp_rdata;
                end
            end
            bus3.req_valid = 1'b0;
            check_output($sformatf("w3_%0d_latency", t), 32'(lat), 32'd5);
            check_output($sformatf("w3_%0d_stall_cycles", t), 32'(stall_cnt), 32'd5);
            check_output($sformatf("w3_%0d_rdata", t), val, w3_exp[t]);
            @(posedge clock); #1;
            check_output($sformatf("w3_%0d_pulse_width", t), 32'(bus3.resp_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
